// File: rtl/sprite_compositor.sv
// Sprite compositor: overlays a ROM-backed sprite on a background colour with a
// fixed 3-cycle pixel pipeline. Define SPRITE_COMPOSITOR_BLINK_EN to add frame-based blinking.
module sprite_compositor #(
    parameter int          SPR_W        = 584,
    parameter int          SPR_H        = 167,
    parameter logic [11:0] KEY_COLOR    = 12'hFFF,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        video_on,
    input  logic        frame_start,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic        pos_wr,
    output logic        pos_ack,
    input  logic        blink_en,
    input  logic [11:0] bg_color,
    output logic [7:0]  rom_row,
    output logic [9:0]  rom_col,
    input  logic [11:0] rom_data,
    output logic [11:0] rgb_out
);

    localparam logic [10:0] SPR_W_L = 11'(SPR_W);
    localparam logic [10:0] SPR_H_L = 11'(SPR_H);

    logic [9:0]  act_x_r;
    logic [9:0]  act_y_r;
    logic [9:0]  pend_x_r;
    logic [9:0]  pend_y_r;
    logic        pend_r;

    logic [10:0] x_end_s;
    logic [10:0] y_end_s;
    logic        hit_x_s;
    logic        hit_y_s;
    logic        visible_s;
    logic        hit_s;
    logic [9:0]  dx_s;
    logic [9:0]  dy_s;

    logic        hit_d1_r;
    logic        hit_d2_r;
    logic        von_d1_r;
    logic        von_d2_r;

`ifdef SPRITE_COMPOSITOR_BLINK_EN
    typedef enum logic {SHOW = 1'b0, HIDE = 1'b1} blink_state_t;

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    blink_state_t     blink_state_r;
    logic [CNT_W-1:0] frame_cnt_r;

    // Blink FSM: toggles SHOW/HIDE every BLINK_FRAMES frame_start pulses while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_state_r <= SHOW;
            frame_cnt_r   <= '0;
        end else if (!blink_en) begin
            blink_state_r <= SHOW;
            frame_cnt_r   <= '0;
        end else if (frame_start) begin
            if (frame_cnt_r == CNT_LAST) begin
                frame_cnt_r <= '0;
                case (blink_state_r)
                    SHOW:    blink_state_r <= HIDE;
                    HIDE:    blink_state_r <= SHOW;
                    default: blink_state_r <= SHOW;
                endcase
            end else begin
                frame_cnt_r <= frame_cnt_r + CNT_W'(1);
            end
        end else begin
            blink_state_r <= blink_state_r;
            frame_cnt_r   <= frame_cnt_r;
        end
    end

    assign visible_s = (blink_state_r == SHOW);
`else
    // blink_en has no effect in this build; OR-ing with 1 keeps the port referenced.
    assign visible_s = 1'b1 | blink_en;
`endif

    // 11-bit window bounds so a sprite hanging past the screen edge clips instead of wrapping.
    assign x_end_s   = {1'b0, act_x_r} + SPR_W_L;
    assign y_end_s   = {1'b0, act_y_r} + SPR_H_L;
    assign hit_x_s   = ({1'b0, pix_x} >= {1'b0, act_x_r}) && ({1'b0, pix_x} < x_end_s);
    assign hit_y_s   = ({1'b0, pix_y} >= {1'b0, act_y_r}) && ({1'b0, pix_y} < y_end_s);
    assign hit_s     = hit_x_s && hit_y_s && visible_s;
    assign dx_s      = pix_x - act_x_r;
    assign dy_s      = pix_y - act_y_r;

    // Position double-buffer: writes land in pending regs and reach the active regs only on frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_x_r  <= 10'd0;
            act_y_r  <= 10'd0;
            pend_x_r <= 10'd0;
            pend_y_r <= 10'd0;
            pend_r   <= 1'b0;
            pos_ack  <= 1'b0;
        end else if (frame_start && pos_wr) begin
            act_x_r  <= pos_x;
            act_y_r  <= pos_y;
            pend_x_r <= pos_x;
            pend_y_r <= pos_y;
            pend_r   <= 1'b0;
            pos_ack  <= 1'b1;
        end else if (frame_start && pend_r) begin
            act_x_r  <= pend_x_r;
            act_y_r  <= pend_y_r;
            pend_r   <= 1'b0;
            pos_ack  <= 1'b1;
        end else if (pos_wr) begin
            pend_x_r <= pos_x;
            pend_y_r <= pos_y;
            pend_r   <= 1'b1;
            pos_ack  <= 1'b0;
        end else begin
            pos_ack  <= 1'b0;
        end
    end

    // Pixel pipeline: address at N+1, flags aligned to ROM data at N+2, colour at N+3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_row  <= 8'd0;
            rom_col  <= 10'd0;
            hit_d1_r <= 1'b0;
            hit_d2_r <= 1'b0;
            von_d1_r <= 1'b0;
            von_d2_r <= 1'b0;
            rgb_out  <= 12'h000;
        end else begin
            if (hit_s) begin
                rom_row <= dy_s[7:0];
                rom_col <= dx_s;
            end else begin
                rom_row <= 8'd0;
                rom_col <= 10'd0;
            end
            hit_d1_r <= hit_s;
            von_d1_r <= video_on;
            hit_d2_r <= hit_d1_r;
            von_d2_r <= von_d1_r;
            if (!von_d2_r) begin
                rgb_out <= 12'h000;
            end else if (hit_d2_r && (rom_data != KEY_COLOR)) begin
                rgb_out <= rom_data;
            end else begin
                rgb_out <= bg_color;
            end
        end
    end

endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Parameters
REQ-001 SHALL have parameter SPR_W, default 584: sprite width in pixels (ROM columns).
REQ-002 SHALL have parameter SPR_H, default 167: sprite height in pixels (ROM rows).
REQ-003 SHALL have parameter KEY_COLOR, default 12'hFFF: transparent colour.
REQ-004 SHALL have parameter BLINK_FRAMES, default 30: frames per blink phase.

Interface
REQ-005 SHALL have port clk, input, 1: single system/pixel clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port pix_x, input, 10: current pixel column from VGA timing.
REQ-008 SHALL have port pix_y, input, 10: current pixel row from VGA timing.
REQ-009 SHALL have port video_on, input, 1: visible-area flag.
REQ-010 SHALL have port frame_start, input, 1: one-cycle pulse at start of each frame.
REQ-011 SHALL have port pos_x, input, 10: requested sprite left edge.
REQ-012 SHALL have port pos_y, input, 10: requested sprite top edge.
REQ-013 SHALL have port pos_wr, input, 1: write strobe for pos_x/pos_y.
REQ-014 SHALL have port pos_ack, output, 1: one-cycle pulse when a written position is applied.
REQ-015 SHALL have port blink_en, input, 1: enables blinking (used only with the macro).
REQ-016 SHALL have port bg_color, input, 12: background colour (RGB444).
REQ-017 SHALL have port rom_row, output, 8: row address to the sprite ROM.
REQ-018 SHALL have port rom_col, output, 10: column address to the sprite ROM.
REQ-019 SHALL have port rom_data, input, 12: ROM colour, registered, valid 1 cycle after the address.
REQ-020 SHALL have port rgb_out, output, 12: composited pixel colour.

Function
REQ-021 Hit SHALL be pos_x<=pix_x<pos_x+SPR_W and pos_y<=pix_y<pos_y+SPR_H, using active position registers and 11-bit sums so there is no wrap; anything past the screen edge is clipped.
REQ-022 On a hit, the block SHALL register rom_row=pix_y-pos_y and rom_col=pix_x-pos_x at cycle N+1; on a miss, both SHALL register 0.
REQ-023 Hit and video_on SHALL be delayed two stages to align with rom_data (valid at N+2).
REQ-024 At cycle N+3, rgb_out SHALL be 0 if delayed video_on=0.
REQ-025 Otherwise at N+3, rgb_out SHALL be rom_data if delayed hit=1, sprite visible and rom_data!=KEY_COLOR; else bg_color sampled at N+2.
REQ-026 Fixed latency from pix_x/pix_y to rgb_out SHALL be 3 cycles, with no bubbles.
REQ-027 pos_wr SHALL load pending registers and set a pend flag; multiple writes before frame_start SHALL leave the last one in the pending registers.
REQ-028 When frame_start=1 and pend=1, the pending position SHALL be copied to the active registers, pend cleared and pos_ack pulsed next cycle.
REQ-029 When pos_wr and frame_start coincide, the new pos_x/pos_y SHALL be applied directly to the active registers, pend cleared and pos_ack pulsed.
REQ-030 Active position SHALL never change outside a frame_start cycle (no tearing).

Reset
REQ-031 On rst_n=0, outputs SHALL be rgb_out=0, rom_row=0, rom_col=0 and pos_ack=0.
REQ-032 On rst_n=0, active/pending position SHALL be 0, pend=0, all pipeline flags 0, blink state SHOW and frame counter 0.
REQ-033 Reset assertion mid-frame SHALL discard in-flight pipeline data; the first valid output follows 3 cycles after release.

Configuration
REQ-034 Macro SPRITE_COMPOSITOR_BLINK_EN, when defined, SHALL compile in a two-state FSM SHOW/HIDE clocked by frame_start.
REQ-035 With the macro, a frame counter SHALL count frame_start pulses while blink_en=1, toggling state and clearing after BLINK_FRAMES pulses.
REQ-036 With the macro, blink_en=0 SHALL force SHOW with counter 0, and HIDE SHALL treat hits as misses.
REQ-037 Without the macro, blink_en SHALL be ignored and the sprite always visible.

Verification
REQ-038 Reset, pos (100,50) written and frame_start pulsed; pix (100,50), video_on=1 -> rom_row=0, rom_col=0 at N+1; rom_data=12'h7F9 yields rgb_out=12'h7F9 at N+3; pos_ack pulses once.
REQ-039 pix (99,50) and (684,50) with pos (100,50) -> miss, rgb_out=bg_color; pix (683,216) -> rom_row=166, rom_col=583.
REQ-040 rom_data=12'hFFF on a hit, bg_color=12'h00F -> rgb_out=12'h00F.
REQ-041 pos_wr (200,10) mid-frame -> active unchanged until frame_start, then applied with pos_ack; pos_wr coincident with frame_start -> applied same edge.
REQ-042 video_on=0 on a hit -> rgb_out=0; rst_n pulsed mid-line -> all outputs 0 immediately.
REQ-043 With the macro, blink_en=1 and BLINK_FRAMES=2 -> sprite hidden in frames 3-4 and shown in 5-6; without the macro -> always shown.
